// File: rtl/alu_pkg.sv
// Shared op-code encoding and default operand width for the bitwise logic unit.
package alu_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOT  = 3'b110,
    OP_ACC  = 3'b111
  } op_e;

endpackage

// File: rtl/logic_flags.sv
// Result flags: all-zeros, odd parity and all-ones of a WIDTH-bit value.
// Purely combinational; sits on the next-result path so flags register with r.
module logic_flags #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  output logic             zero,
  output logic             parity,
  output logic             ones
);

  assign zero   = ~|value;
  assign parity = ^value;
  assign ones   = &value;

endmodule

// File: rtl/bitwise_logic_unit.sv
// Bitwise op unit with optional XOR accumulator; one-cycle registered result and flags.
// Valid/ready: in_ready = !out_valid || out_ready, so a held result stalls new requests.
module bitwise_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter bit ACC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             parity,
  output logic             ones
);

  logic             accept;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] nxt_r;
  logic             nxt_zero;
  logic             nxt_parity;
  logic             nxt_ones;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A clear in the same cycle as an ACC request wipes the old value first.
  assign acc_base = acc_clr ? '0 : acc;

  always_comb begin
    nxt_r = '0;
    case (op)
      OP_AND:  nxt_r = a & b;
      OP_OR:   nxt_r = a | b;
      OP_XOR:  nxt_r = a ^ b;
      OP_NAND: nxt_r = ~(a & b);
      OP_NOR:  nxt_r = ~(a | b);
      OP_XNOR: nxt_r = ~(a ^ b);
      OP_NOT:  nxt_r = ~a;
      OP_ACC:  nxt_r = ACC_EN ? (acc_base ^ a ^ b) : (a ^ b);
      default: nxt_r = '0;
    endcase
  end

  logic_flags #(.WIDTH(WIDTH)) u_flags (
    .value  (nxt_r),
    .zero   (nxt_zero),
    .parity (nxt_parity),
    .ones   (nxt_ones)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      r         <= '0;
      zero      <= 1'b1;
      parity    <= 1'b0;
      ones      <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        r         <= nxt_r;
        zero      <= nxt_zero;
        parity    <= nxt_parity;
        ones      <= nxt_ones;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  generate
    if (ACC_EN) begin : g_acc
      logic acc_upd;
      assign acc_upd = accept && (op == OP_ACC);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc <= '0;
        end else if (acc_upd) begin
          acc <= nxt_r;
        end else if (acc_clr) begin
          acc <= '0;
        end
      end
    end else begin : g_no_acc
      assign acc = '0;
    end
  endgenerate

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Randomized and directed bench for bitwise_logic_unit against a cycle-level reference model.
module tb_bitwise_logic_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, acc_clr, out_valid, out_ready;
  logic [W-1:0] a, b, r;
  logic [2:0]   op;
  logic         zero, parity, ones;

  logic         in_valid8, in_ready8, acc_clr8, out_valid8, out_ready8;
  logic [7:0]   a8, b8, r8;
  logic [2:0]   op8;
  logic         zero8, parity8, ones8;

  always #5 clk = ~clk;

  bitwise_logic_unit #(.WIDTH(W), .ACC_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .r(r), .zero(zero), .parity(parity), .ones(ones)
  );

  bitwise_logic_unit #(.WIDTH(8), .ACC_EN(1'b0)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .acc_clr(acc_clr8), .out_valid(out_valid8),
    .out_ready(out_ready8), .r(r8), .zero(zero8), .parity(parity8), .ones(ones8)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: accumulator, last result, result-pending flag.
  logic [W-1:0] m_acc, m_r;
  logic         m_vld;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_logic(input logic [2:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x & y);
      3'd4:    return ~(x | y);
      3'd5:    return ~(x ^ y);
      default: return ~x;
    endcase
  endfunction

  task automatic model_reset();
    m_acc = '0;
    m_r   = '0;
    m_vld = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_vld));
    check({tag, ".r"},         64'(r),         64'(m_r));
    check({tag, ".zero"},      64'(zero),      64'(m_r == '0));
    check({tag, ".parity"},    64'(parity),    64'($countones(m_r) % 2));
    check({tag, ".ones"},      64'(ones),      64'(m_r == {W{1'b1}}));
    check({tag, ".in_ready"},  64'(in_ready),  64'(!m_vld || out_ready));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick(input string tag);
    logic accepted;
    @(posedge clk);
    accepted = in_valid && (!m_vld || out_ready);
    if (acc_clr) m_acc = '0;
    if (accepted) begin
      if (op == 3'd7) begin
        m_acc = m_acc ^ a ^ b;
        m_r   = m_acc;
      end else begin
        m_r = ref_logic(op, a, b);
      end
      m_vld = 1'b1;
    end else if (out_ready) begin
      m_vld = 1'b0;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic clr, input logic ordy);
    in_valid  = v;
    op        = o;
    a         = x;
    b         = y;
    acc_clr   = clr;
    out_ready = ordy;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
    in_valid8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; acc_clr8 = 1'b0; out_ready8 = 1'b1;
    model_reset();

    #1;
    check_outputs("reset");
    #11;
    rst = 1'b0;
    #1;
    check("post_reset.in_ready", 64'(in_ready), 64'(1));

    drive(1'b1, 3'd2, 16'h00FF, 16'h0F0F, 1'b0, 1'b1);
    tick("xor");
    check("xor.r_const", 64'(r), 64'h0FF0);
    check("xor.zero_const", 64'(zero), 64'(0));
    check("xor.parity_const", 64'(parity), 64'(0));

    drive(1'b1, 3'd3, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    tick("nand");
    check("nand.r_const", 64'(r), 64'h0000);
    check("nand.zero_const", 64'(zero), 64'(1));
    drive(1'b1, 3'd4, 16'h0000, 16'h0000, 1'b0, 1'b1);
    tick("nor");
    check("nor.ones_const", 64'(ones), 64'(1));

    // Backpressure: first result held, second request waits.
    drive(1'b1, 3'd2, 16'h0001, 16'h0002, 1'b0, 1'b1);
    tick("bp_first");
    drive(1'b1, 3'd0, 16'hFFFF, 16'h1234, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick("bp_hold");
      check("bp_hold.r_const", 64'(r), 64'h0003);
      check("bp_hold.in_ready_const", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    tick("bp_release");
    check("bp_release.r_const", 64'(r), 64'h1234);
    drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
    tick("bp_drain");

    // Accumulator sequence.
    drive(1'b0, 3'd7, '0, '0, 1'b1, 1'b1);
    tick("acc_clr");
    drive(1'b1, 3'd7, 16'h1234, 16'h0000, 1'b0, 1'b1);
    tick("acc1");
    check("acc1.r_const", 64'(r), 64'h1234);
    drive(1'b1, 3'd7, 16'h1234, 16'h0001, 1'b0, 1'b1);
    tick("acc2");
    check("acc2.r_const", 64'(r), 64'h0001);
    drive(1'b1, 3'd7, 16'h00F0, 16'h000F, 1'b1, 1'b1);
    tick("acc3");
    check("acc3.r_const", 64'(r), 64'h00FF);
    drive(1'b1, 3'd7, 16'h0001, 16'h0000, 1'b1, 1'b1);
    tick("acc4");
    check("acc4.r_const", 64'(r), 64'h0001);

    // Reset mid-operation: result pending, acc = 1.
    drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("mid_reset");
    #2;
    rst = 1'b0;
    drive(1'b1, 3'd7, 16'h0055, 16'h0000, 1'b0, 1'b1);
    tick("acc_after_reset");
    check("acc_after_reset.r_const", 64'(r), 64'h0055);

    // WIDTH=8, no accumulator.
    drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
    in_valid8 = 1'b1; op8 = 3'd6; a8 = 8'hA5; b8 = 8'h3C;
    tick("w8_idle1");
    check("w8_not.r", 64'(r8), 64'h5A);
    check("w8_not.parity", 64'(parity8), 64'(0));
    check("w8_not.out_valid", 64'(out_valid8), 64'(1));
    op8 = 3'd7; a8 = 8'h0F; b8 = 8'hFF; acc_clr8 = 1'b1;
    tick("w8_idle2");
    check("w8_op7.r", 64'(r8), 64'hF0);
    check("w8_op7.zero", 64'(zero8), 64'(0));
    check("w8_op7.ones", 64'(ones8), 64'(0));
    in_valid8 = 1'b0; acc_clr8 = 1'b0;

    // Randomized traffic with random backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
            16'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_unit.md
BITWISE_LOGIC_UNIT -- requirements
Module: bitwise_logic_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter WIDTH SHALL default to 16 and SHALL set the operand and result width in bits (legal range 2..64).
REQ-003 Parameter ACC_EN SHALL default to 1; a value of 1 includes the accumulator, and 0 removes it (op 111 then behaves as XOR).
REQ-004 Port clk SHALL be an input, 1 bit wide: the clock; all state SHALL update on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-006 Port in_valid SHALL be an input, 1 bit wide: the request operands are valid.
REQ-007 Port in_ready SHALL be an output, 1 bit wide: the block can accept a request.
REQ-008 Port a SHALL be an input, WIDTH bits wide: operand A.
REQ-009 Port b SHALL be an input, WIDTH bits wide: operand B.
REQ-010 Port op SHALL be an input, 3 bits wide: operation select.
REQ-011 Port acc_clr SHALL be an input, 1 bit wide: synchronous accumulator clear.
REQ-012 Port out_valid SHALL be an output, 1 bit wide: the result is valid.
REQ-013 Port out_ready SHALL be an input, 1 bit wide: the consumer accepts the result.
REQ-014 Port r SHALL be an output, WIDTH bits wide: the registered result.
REQ-015 Port zero SHALL be an output, 1 bit wide: r is all zeros.
REQ-016 Port parity SHALL be an output, 1 bit wide: XOR-reduction (odd parity) of r.
REQ-017 Port ones SHALL be an output, 1 bit wide: r is all ones.

Function
REQ-018 Op codes SHALL map as: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT a (b ignored), 111 ACC (r = acc ^ a ^ b).
REQ-019 A request SHALL be accepted on a rising edge when in_valid && in_ready.
REQ-020 in_ready SHALL equal !out_valid || out_ready, with no registered stall.
REQ-021 The latency from acceptance to out_valid SHALL be 1 cycle, with a throughput of 1 request per cycle under out_ready=1.
REQ-022 While out_valid && !out_ready, r, zero, parity and ones SHALL hold stable.
REQ-023 out_valid SHALL clear after a consumed result (out_valid && out_ready) only when no new request is accepted in the same cycle.
REQ-024 The flags zero, parity and ones SHALL be registered alongside r and SHALL be consistent with r every cycle.
REQ-025 For an accepted ACC request, the accumulator SHALL update to acc ^ a ^ b, and r SHALL take the same value.
REQ-026 The accumulator SHALL change only on an accepted ACC request or on acc_clr.
REQ-027 acc_clr SHALL be sampled every cycle, independent of the handshake.
REQ-028 acc_clr with no accepted ACC request SHALL set acc to 0.
REQ-029 When acc_clr and an accepted ACC request coincide, the clear SHALL apply first: acc = a ^ b, and r = a ^ b.
REQ-030 A non-ACC request SHALL never modify acc.
REQ-031 Results SHALL be exactly WIDTH bits wide, with no carry, overflow or sign semantics.
REQ-032 A request with in_valid low SHALL be ignored regardless of op, a, b.

Reset
REQ-033 Reset SHALL force out_valid=0, r=0, zero=1, parity=0, ones=0 and acc=0 asynchronously, mid-operation included.
REQ-034 A pending unconsumed result SHALL be discarded on reset.
REQ-035 in_ready SHALL read 1 during and after reset.

Structure
REQ-036 Op-code constants (OP_AND..OP_ACC) and the default WIDTH SHALL reside in the shared package alu_pkg.
REQ-037 Flag generation SHALL be a sub-module, logic_flags (parameter WIDTH; input value; outputs zero, parity, ones), instantiated on the next-result path.
REQ-038 The datapath SHALL be a single combinational op mux feeding one output register stage and the accumulator register.

Verification
REQ-039 Scenario XOR: WIDTH=16, a=0x00FF, b=0x0F0F, op=010, out_ready=1 -> the next cycle SHALL show r=0x0FF0, zero=0, parity=0, ones=0.
REQ-040 Scenario NAND: a=0xFFFF, b=0xFFFF, op=011 -> r SHALL be 0x0000, zero=1, and on a following NOR of 0x0000 with 0x0000, ones=1.
REQ-041 Scenario backpressure: result held with out_ready=0 -> in_ready SHALL be 0, a second in_valid SHALL NOT be accepted, and r SHALL be stable for 5 cycles; releasing out_ready SHALL produce the second result one cycle later.
REQ-042 Scenario ACC: acc_clr, then ACC a=0x1234, b=0x0000 -> r SHALL be 0x1234; then ACC a=0x1234, b=0x0001 -> r SHALL be 0x0001; then acc_clr together with ACC a=0x00F0, b=0x000F -> r SHALL be 0x00FF.
REQ-043 Scenario reset mid-operation: rst asserted while out_valid=1 and acc=0x0001 -> out_valid=0, r=0 and acc=0 SHALL hold before the next clock edge.
REQ-044 Scenario WIDTH=8, ACC_EN=0: NOT a=0xA5 -> r SHALL be 0x5A, parity=0; and op 111 with a=0x0F, b=0xFF -> r SHALL be 0xF0.
